// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute, drives PC, IR,
// memory handshake, ALU and regfile controls, with a per-access memory watchdog.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       pc_en,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       mem_timeout,
  output logic       halted
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JR, S_ABORT, S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_wcnt;
  logic             w_is_mem;
  logic             w_tmo;
  logic             w_pcwrite;
  logic             w_branch;

  assign w_is_mem = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // Only the last permitted wait cycle can abort; a ready on that same cycle completes instead.
  assign w_tmo    = (MEM_TIMEOUT != 0) && w_is_mem && !mem_ready && (r_wcnt == TMO_LAST);
  assign pc_en    = w_pcwrite | (w_branch & zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_state_nx != r_state)
        r_wcnt <= '0;
      else if (w_is_mem && !mem_ready)
        r_wcnt <= r_wcnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    pcsrc       = 2'b00;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    mem_timeout = 1'b0;
    halted      = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_nx = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite    = 1'b1;
          w_pcwrite  = 1'b1;
          w_state_nx = S_DECODE;
        end else if (w_tmo) begin
          w_state_nx = S_ABORT;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW)            w_state_nx = S_MEMADR;
        else if (opcode == OP_RTYPE && funct == FN_JR)     w_state_nx = S_JR;
        else if (opcode == OP_RTYPE)                       w_state_nx = S_EXECUTE;
        else if (opcode == OP_BEQ)                         w_state_nx = S_BRANCH;
        else if (opcode == OP_ADDI)                        w_state_nx = S_ADDIEX;
        else if (opcode == OP_J)                           w_state_nx = S_JUMP;
        else if (ILLEGAL_TRAP != 0)                        w_state_nx = S_HALT;
        else                                               w_state_nx = S_FETCH;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        w_state_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)  w_state_nx = S_MEMWB;
        else if (w_tmo) w_state_nx = S_ABORT;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        w_state_nx = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready)  w_state_nx = S_FETCH;
        else if (w_tmo) w_state_nx = S_ABORT;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        w_state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        w_state_nx = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        w_branch   = 1'b1;
        pcsrc      = 2'b01;
        w_state_nx = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        w_state_nx = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        w_state_nx = S_FETCH;
      end
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        pcsrc      = 2'b10;
        w_state_nx = S_FETCH;
      end
      S_JR: begin
        w_pcwrite  = 1'b1;
        pcsrc      = 2'b11;
        w_state_nx = S_FETCH;
      end
      // Dead cycle with request dropped so the aborted access is cleanly terminated.
      S_ABORT: begin
        mem_timeout = 1'b1;
        w_state_nx  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed instruction sequences, two instances
// (illegal opcode trapping vs. treated as NOP), watchdog set to 4 wait cycles.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  logic       a_req[2], a_we[2], a_iord[2], a_irw[2], a_pcen[2], a_rd[2], a_m2r[2];
  logic       a_rw[2], a_asa[2], a_to[2], a_h[2];
  logic [1:0] a_pcsrc[2], a_asb[2], a_aop[2];

  logic [33:0] q_exp[$];
  string       q_nm[$];
  int          n_chk = 0;
  int          n_fail = 0;

  logic [16:0] E_IDLE, E_FR, E_FW, E_DEC, E_MA, E_MRD, E_MWB, E_MW, E_EX, E_AWB;
  logic [16:0] E_BR1, E_BR0, E_AEX, E_AWB2, E_J, E_JR, E_TO, E_H;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_req[0]), .mem_we(a_we[0]), .iord(a_iord[0]),
    .irwrite(a_irw[0]), .pc_en(a_pcen[0]), .pcsrc(a_pcsrc[0]), .regdst(a_rd[0]),
    .memtoreg(a_m2r[0]), .regwrite(a_rw[0]), .alusrca(a_asa[0]), .alusrcb(a_asb[0]),
    .aluop(a_aop[0]), .mem_timeout(a_to[0]), .halted(a_h[0])
  );

  mips_mc_ctrl #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_req[1]), .mem_we(a_we[1]), .iord(a_iord[1]),
    .irwrite(a_irw[1]), .pc_en(a_pcen[1]), .pcsrc(a_pcsrc[1]), .regdst(a_rd[1]),
    .memtoreg(a_m2r[1]), .regwrite(a_rw[1]), .alusrca(a_asa[1]), .alusrcb(a_asb[1]),
    .aluop(a_aop[1]), .mem_timeout(a_to[1]), .halted(a_h[1])
  );

  // Field order: req we iord irwrite pc_en pcsrc regdst memtoreg regwrite alusrca alusrcb aluop timeout halted
  function automatic logic [16:0] mk(input logic req, we, io, irw, pcen, input logic [1:0] ps,
                                     input logic rd, m2r, rw, asa, input logic [1:0] asb, aop,
                                     input logic to, h);
    return {req, we, io, irw, pcen, ps, rd, m2r, rw, asa, asb, aop, to, h};
  endfunction

  function automatic logic [16:0] got(input int i);
    return {a_req[i], a_we[i], a_iord[i], a_irw[i], a_pcen[i], a_pcsrc[i], a_rd[i], a_m2r[i],
            a_rw[i], a_asa[i], a_asb[i], a_aop[i], a_to[i], a_h[i]};
  endfunction

  task automatic cyc2(input logic r, mr, z, input logic [5:0] op, fn,
                      input logic [16:0] e0, e1, input string nm);
    @(posedge clk);
    #1;
    rst_n = r; mem_ready = mr; zero = z; opcode = op; funct = fn;
    q_exp.push_back({e0, e1});
    q_nm.push_back(nm);
  endtask

  task automatic cyc(input logic r, mr, z, input logic [5:0] op, fn,
                     input logic [16:0] e, input string nm);
    cyc2(r, mr, z, op, fn, e, e, nm);
  endtask

  // Monitor: the controller presents a full output vector every cycle.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [33:0] e;
      string       nm;
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      for (int i = 0; i < 2; i++) begin
        logic [16:0] w;
        w = (i == 0) ? e[33:17] : e[16:0];
        n_chk++;
        if (got(i) !== w) begin
          n_fail++;
          $display("FAIL %s dut%0d got %05h want %05h", nm, i, got(i), w);
        end
      end
    end
  end

  initial begin
    E_IDLE = '0;
    E_FR   = mk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,2'b00,0,0);
    E_FW   = mk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,2'b00,0,0);
    E_DEC  = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00,0,0);
    E_MA   = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00,0,0);
    E_MRD  = mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,0,0);
    E_MWB  = mk(0,0,0,0,0,2'b00,0,1,1,0,2'b00,2'b00,0,0);
    E_MW   = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,0,0);
    E_EX   = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,2'b10,0,0);
    E_AWB  = mk(0,0,0,0,0,2'b00,1,0,1,0,2'b00,2'b00,0,0);
    E_BR1  = mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,2'b01,0,0);
    E_BR0  = mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,2'b01,0,0);
    E_AEX  = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00,0,0);
    E_AWB2 = mk(0,0,0,0,0,2'b00,0,0,1,0,2'b00,2'b00,0,0);
    E_J    = mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,2'b00,0,0);
    E_JR   = mk(0,0,0,0,1,2'b11,0,0,0,0,2'b00,2'b00,0,0);
    E_TO   = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,2'b00,1,0);
    E_H    = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,2'b00,0,1);

    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    cyc(0, 1, 0, 6'h00, 6'h00, E_IDLE, "reset");
    cyc(0, 1, 0, 6'h00, 6'h00, E_IDLE, "reset");
    cyc(1, 1, 0, 6'h00, 6'h00, E_IDLE, "idle_after_reset");
    // lw, zero wait
    cyc(1, 1, 0, 6'h23, 6'h00, E_FR,   "lw_fetch");
    cyc(1, 1, 0, 6'h23, 6'h00, E_DEC,  "lw_decode");
    cyc(1, 1, 0, 6'h23, 6'h00, E_MA,   "lw_memadr");
    cyc(1, 1, 0, 6'h23, 6'h00, E_MRD,  "lw_memrd");
    cyc(1, 1, 0, 6'h23, 6'h00, E_MWB,  "lw_memwb");
    // sw, zero wait
    cyc(1, 1, 0, 6'h2b, 6'h00, E_FR,   "sw_fetch");
    cyc(1, 1, 0, 6'h2b, 6'h00, E_DEC,  "sw_decode");
    cyc(1, 1, 0, 6'h2b, 6'h00, E_MA,   "sw_memadr");
    cyc(1, 1, 0, 6'h2b, 6'h00, E_MW,   "sw_memwr");
    // R-type add
    cyc(1, 1, 0, 6'h00, 6'h20, E_FR,   "r_fetch");
    cyc(1, 1, 0, 6'h00, 6'h20, E_DEC,  "r_decode");
    cyc(1, 1, 0, 6'h00, 6'h20, E_EX,   "r_execute");
    cyc(1, 1, 0, 6'h00, 6'h20, E_AWB,  "r_aluwb");
    // addi
    cyc(1, 1, 0, 6'h08, 6'h00, E_FR,   "addi_fetch");
    cyc(1, 1, 0, 6'h08, 6'h00, E_DEC,  "addi_decode");
    cyc(1, 1, 0, 6'h08, 6'h00, E_AEX,  "addi_ex");
    cyc(1, 1, 0, 6'h08, 6'h00, E_AWB2, "addi_wb");
    // beq taken / not taken
    cyc(1, 1, 0, 6'h04, 6'h00, E_FR,   "beq1_fetch");
    cyc(1, 1, 0, 6'h04, 6'h00, E_DEC,  "beq1_decode");
    cyc(1, 1, 1, 6'h04, 6'h00, E_BR1,  "beq_taken");
    cyc(1, 1, 0, 6'h04, 6'h00, E_FR,   "beq0_fetch");
    cyc(1, 1, 0, 6'h04, 6'h00, E_DEC,  "beq0_decode");
    cyc(1, 1, 0, 6'h04, 6'h00, E_BR0,  "beq_not_taken");
    // j and jr
    cyc(1, 1, 0, 6'h02, 6'h00, E_FR,   "j_fetch");
    cyc(1, 1, 0, 6'h02, 6'h00, E_DEC,  "j_decode");
    cyc(1, 1, 0, 6'h02, 6'h00, E_J,    "j_jump");
    cyc(1, 1, 0, 6'h00, 6'h08, E_FR,   "jr_fetch");
    cyc(1, 1, 0, 6'h00, 6'h08, E_DEC,  "jr_decode");
    cyc(1, 1, 0, 6'h00, 6'h08, E_JR,   "jr_jr");
    // fetch with three wait cycles, then beq not taken
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 6'h04, 6'h00, E_FW, "fetch_wait");
    cyc(1, 1, 0, 6'h04, 6'h00, E_FR,   "fetch_wait_done");
    cyc(1, 1, 0, 6'h04, 6'h00, E_DEC,  "fw_decode");
    cyc(1, 1, 0, 6'h04, 6'h00, E_BR0,  "fw_branch");
    // lw with three waits, ready on the last permitted cycle wins over timeout
    cyc(1, 1, 0, 6'h23, 6'h00, E_FR,   "lwd_fetch");
    cyc(1, 1, 0, 6'h23, 6'h00, E_DEC,  "lwd_decode");
    cyc(1, 1, 0, 6'h23, 6'h00, E_MA,   "lwd_memadr");
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 6'h23, 6'h00, E_MRD, "lwd_memrd_wait");
    cyc(1, 1, 0, 6'h23, 6'h00, E_MRD,  "lwd_memrd_ready");
    cyc(1, 1, 0, 6'h23, 6'h00, E_MWB,  "lwd_memwb");
    // sw with memory stuck: watchdog abort after 4 wait cycles
    cyc(1, 1, 0, 6'h2b, 6'h00, E_FR,   "swt_fetch");
    cyc(1, 1, 0, 6'h2b, 6'h00, E_DEC,  "swt_decode");
    cyc(1, 1, 0, 6'h2b, 6'h00, E_MA,   "swt_memadr");
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 6'h2b, 6'h00, E_MW, "swt_memwr_wait");
    cyc(1, 0, 0, 6'h2b, 6'h00, E_TO,   "swt_timeout");
    cyc(1, 1, 0, 6'h02, 6'h00, E_FR,   "swt_refetch");
    cyc(1, 1, 0, 6'h02, 6'h00, E_DEC,  "swt_decode2");
    cyc(1, 1, 0, 6'h02, 6'h00, E_J,    "swt_jump");
    // reset asserted in the middle of a memory read
    cyc(1, 1, 0, 6'h23, 6'h00, E_FR,   "rmr_fetch");
    cyc(1, 1, 0, 6'h23, 6'h00, E_DEC,  "rmr_decode");
    cyc(1, 1, 0, 6'h23, 6'h00, E_MA,   "rmr_memadr");
    cyc(1, 0, 0, 6'h23, 6'h00, E_MRD,  "rmr_memrd");
    cyc(0, 0, 0, 6'h23, 6'h00, E_IDLE, "rmr_async_reset");
    cyc(1, 1, 0, 6'h3f, 6'h00, E_IDLE, "ill_idle");
    // illegal opcode: trap instance halts, NOP instance refetches
    cyc(1, 1, 0, 6'h3f, 6'h00, E_FR,   "ill_fetch");
    cyc(1, 1, 0, 6'h3f, 6'h00, E_DEC,  "ill_decode");
    cyc2(1, 1, 0, 6'h3f, 6'h00, E_H, E_FR,  "ill_after1");
    cyc2(1, 1, 0, 6'h3f, 6'h00, E_H, E_DEC, "ill_after2");
    cyc2(1, 1, 0, 6'h3f, 6'h00, E_H, E_FR,  "ill_after3");
    cyc(0, 1, 0, 6'h00, 6'h00, E_IDLE, "halt_reset");
    cyc(1, 1, 0, 6'h00, 6'h00, E_IDLE, "halt_idle");
    cyc(1, 1, 0, 6'h00, 6'h00, E_FR,   "halt_cleared_fetch");

    repeat (2) @(posedge clk);
    n_chk++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d want 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
